// File: rtl/decode_if.sv
// decode_if: IF/ID inputs, write-back port and ID/EX outputs of the decode stage
interface decode_if;
  logic [31:0] instr_if_id;
  logic [31:0] pc_plus4_if_id;
  logic        valid_if_id;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] read_data_1_id_ex;
  logic [31:0] read_data_2_id_ex;
  logic [31:0] extended_branch_offset_id_ex;
  logic [31:0] supposed_next_address_id_ex;
  logic [4:0]  next_instruction_20_16_id_ex;
  logic [4:0]  next_instruction_15_11_id_ex;
  logic [1:0]  ctrl_aluOp_id_ex;
  logic        ctrl_aluSrc_id_ex;
  logic        ctrl_regDest_id_ex;
  logic        ctrl_branch_id_ex;
  logic        ctrl_memRead_id_ex;
  logic        ctrl_memWrite_id_ex;
  logic        ctrl_regWrite_id_ex;
  logic        ctrl_memToReg_id_ex;
  logic        valid_id_ex;
  logic        stall;
  modport master (
    output instr_if_id, pc_plus4_if_id, valid_if_id, flush, wb_we, wb_addr, wb_data,
    input  read_data_1_id_ex, read_data_2_id_ex, extended_branch_offset_id_ex,
           supposed_next_address_id_ex, next_instruction_20_16_id_ex,
           next_instruction_15_11_id_ex, ctrl_aluOp_id_ex, ctrl_aluSrc_id_ex,
           ctrl_regDest_id_ex, ctrl_branch_id_ex, ctrl_memRead_id_ex,
           ctrl_memWrite_id_ex, ctrl_regWrite_id_ex, ctrl_memToReg_id_ex,
           valid_id_ex, stall
  );
  modport slave (
    input  instr_if_id, pc_plus4_if_id, valid_if_id, flush, wb_we, wb_addr, wb_data,
    output read_data_1_id_ex, read_data_2_id_ex, extended_branch_offset_id_ex,
           supposed_next_address_id_ex, next_instruction_20_16_id_ex,
           next_instruction_15_11_id_ex, ctrl_aluOp_id_ex, ctrl_aluSrc_id_ex,
           ctrl_regDest_id_ex, ctrl_branch_id_ex, ctrl_memRead_id_ex,
           ctrl_memWrite_id_ex, ctrl_regWrite_id_ex, ctrl_memToReg_id_ex,
           valid_id_ex, stall
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: MIPS-style ID stage with register file, control decode and ID/EX register.
// Define DECODE_HAZARD_DETECT_EN to enable load-use stall detection.
module decode_stage (
  input logic   clk,
  input logic   reset,
  decode_if.slave d
);
  logic [31:0] rf [32];
  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic        is_r, is_lw, is_sw, is_beq, is_addi, known, bubble, load_use;
  logic [31:0] rd1, rd2;
  always_comb begin
    op      = d.instr_if_id[31:26];
    rs      = d.instr_if_id[25:21];
    rt      = d.instr_if_id[20:16];
    is_r    = op == 6'h00;
    is_lw   = op == 6'h23;
    is_sw   = op == 6'h2b;
    is_beq  = op == 6'h04;
    is_addi = op == 6'h08;
    known   = is_r | is_lw | is_sw | is_beq | is_addi;
    // a register written this cycle is forwarded straight to the read port
    rd1 = rs == 5'd0 ? 32'd0 : (d.wb_we && d.wb_addr == rs) ? d.wb_data : rf[rs];
    rd2 = rt == 5'd0 ? 32'd0 : (d.wb_we && d.wb_addr == rt) ? d.wb_data : rf[rt];
  end
`ifdef DECODE_HAZARD_DETECT_EN
  assign load_use = d.ctrl_memRead_id_ex & d.valid_id_ex & (d.next_instruction_20_16_id_ex != 5'd0) &
                    ((d.next_instruction_20_16_id_ex == rs) |
                     ((is_r | is_sw | is_beq) & (d.next_instruction_20_16_id_ex == rt)));
`else
  assign load_use = 1'b0;
`endif
  assign d.stall = d.valid_if_id & ~d.flush & load_use;
  assign bubble  = d.flush | ~d.valid_if_id | d.stall;
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (d.wb_we && d.wb_addr != 5'd0)
      rf[d.wb_addr] <= d.wb_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      d.read_data_1_id_ex            <= '0;
      d.read_data_2_id_ex            <= '0;
      d.extended_branch_offset_id_ex <= '0;
      d.supposed_next_address_id_ex  <= '0;
      d.next_instruction_20_16_id_ex <= '0;
      d.next_instruction_15_11_id_ex <= '0;
      d.ctrl_aluOp_id_ex             <= '0;
      d.ctrl_aluSrc_id_ex            <= 1'b0;
      d.ctrl_regDest_id_ex           <= 1'b0;
      d.ctrl_branch_id_ex            <= 1'b0;
      d.ctrl_memRead_id_ex           <= 1'b0;
      d.ctrl_memWrite_id_ex          <= 1'b0;
      d.ctrl_regWrite_id_ex          <= 1'b0;
      d.ctrl_memToReg_id_ex          <= 1'b0;
      d.valid_id_ex                  <= 1'b0;
    end else begin
      d.read_data_1_id_ex            <= rd1;
      d.read_data_2_id_ex            <= rd2;
      d.extended_branch_offset_id_ex <= {{16{d.instr_if_id[15]}}, d.instr_if_id[15:0]};
      d.supposed_next_address_id_ex  <= d.pc_plus4_if_id;
      d.next_instruction_20_16_id_ex <= rt;
      d.next_instruction_15_11_id_ex <= d.instr_if_id[15:11];
      d.ctrl_aluOp_id_ex             <= bubble ? 2'b00 : {is_r, is_beq};
      d.ctrl_aluSrc_id_ex            <= ~bubble & (is_lw | is_sw | is_addi);
      d.ctrl_regDest_id_ex           <= ~bubble & is_r;
      d.ctrl_branch_id_ex            <= ~bubble & is_beq;
      d.ctrl_memRead_id_ex           <= ~bubble & is_lw;
      d.ctrl_memWrite_id_ex          <= ~bubble & is_sw;
      d.ctrl_regWrite_id_ex          <= ~bubble & (is_r | is_lw | is_addi);
      d.ctrl_memToReg_id_ex          <= ~bubble & is_lw;
      d.valid_id_ex                  <= ~bubble & known;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, register file, bypass, hazard and bubble behaviour
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  decode_if d ();
  decode_stage dut (.clk(clk), .reset(reset), .d(d));
  always #5 clk = ~clk;
`ifdef DECODE_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  localparam logic [31:0] ADD_8_9_10 = 32'h012A4020;
  localparam logic [31:0] LW_8       = 32'h8C28FFFC;
  localparam logic [31:0] ADD_3_8_2  = 32'h01021820;
  localparam logic [31:0] ADD_3_0_0  = 32'h00001820;
  localparam logic [31:0] BAD_OP     = 32'hFC000000;
  localparam logic [31:0] BEQ        = 32'h1109FFFF;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ctrl(input string tag, input logic [9:0] exp);
    chk(tag, {22'd0, d.ctrl_aluOp_id_ex, d.ctrl_aluSrc_id_ex, d.ctrl_regDest_id_ex,
              d.ctrl_branch_id_ex, d.ctrl_memRead_id_ex, d.ctrl_memWrite_id_ex,
              d.ctrl_regWrite_id_ex, d.ctrl_memToReg_id_ex, d.valid_id_ex}, {22'd0, exp});
  endtask
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    d.instr_if_id = ins;
    d.pc_plus4_if_id = pc;
    d.valid_if_id = 1'b1;
  endtask
  // ctrl vector order: aluOp[1:0] aluSrc regDest branch memRead memWrite regWrite memToReg valid
  initial begin
    d.instr_if_id = LW_8;
    d.pc_plus4_if_id = 32'h44;
    d.valid_if_id = 1'b1;
    d.flush = 1'b0;
    d.wb_we = 1'b0;
    d.wb_addr = '0;
    d.wb_data = '0;
    tick();
    tick();
    ctrl("reset_ctrl", 10'b0);
    chk("reset_rd1", d.read_data_1_id_ex, 0);
    chk("reset_off", d.extended_branch_offset_id_ex, 0);
    chk("reset_nxt", d.supposed_next_address_id_ex, 0);
    chk("reset_stall", {31'd0, d.stall}, 0);
    reset = 1'b1;
    d.valid_if_id = 1'b0;
    d.wb_we = 1'b1; d.wb_addr = 5'd9; d.wb_data = 32'd5;
    tick();
    d.wb_addr = 5'd10; d.wb_data = 32'd7;
    tick();
    d.wb_we = 1'b0;
    ctrl("invalid_bubble", 10'b0);
    issue(ADD_8_9_10, 32'h4);
    tick();
    ctrl("add_ctrl", 10'b10_0100_0101);
    chk("add_rd1", d.read_data_1_id_ex, 5);
    chk("add_rd2", d.read_data_2_id_ex, 7);
    chk("add_rd", {27'd0, d.next_instruction_15_11_id_ex}, 8);
    issue(LW_8, 32'h100);
    tick();
    ctrl("lw_ctrl", 10'b00_1001_0111);
    chk("lw_off", d.extended_branch_offset_id_ex, 32'hFFFFFFFC);
    chk("lw_nxt", d.supposed_next_address_id_ex, 32'h100);
    chk("lw_rt", {27'd0, d.next_instruction_20_16_id_ex}, 8);
    issue(ADD_3_8_2, 32'h104);
    #1;
    chk("lu_stall", {31'd0, d.stall}, {31'd0, HZ});
    tick();
    if (HZ) begin
      ctrl("lu_bubble", 10'b0);
      chk("lu_stall_one", {31'd0, d.stall}, 0);
      tick();
    end
    ctrl("lu_add", 10'b10_0100_0101);
    chk("lu_add_rd", {27'd0, d.next_instruction_15_11_id_ex}, 3);
    d.wb_we = 1'b1; d.wb_addr = 5'd9; d.wb_data = 32'hDEADBEEF;
    issue(ADD_8_9_10, 32'h108);
    tick();
    d.wb_we = 1'b0;
    chk("bypass_rd1", d.read_data_1_id_ex, 32'hDEADBEEF);
    chk("bypass_rd2", d.read_data_2_id_ex, 7);
    tick();
    chk("written_rd1", d.read_data_1_id_ex, 32'hDEADBEEF);
    d.wb_we = 1'b1; d.wb_addr = 5'd0; d.wb_data = 32'h1234;
    issue(ADD_3_0_0, 32'h10C);
    tick();
    d.wb_we = 1'b0;
    chk("r0_same_cycle", d.read_data_1_id_ex, 0);
    tick();
    chk("r0_after", d.read_data_1_id_ex, 0);
    chk("r0_after_rt", d.read_data_2_id_ex, 0);
    issue(LW_8, 32'h110);
    tick();
    issue(ADD_3_8_2, 32'h114);
    d.flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, d.stall}, 0);
    tick();
    d.flush = 1'b0;
    ctrl("flush_bubble", 10'b0);
    issue(LW_8, 32'h118);
    tick();
    issue(ADD_3_8_2, 32'h11C);
    d.valid_if_id = 1'b0;
    #1;
    chk("inv_stall", {31'd0, d.stall}, 0);
    tick();
    ctrl("inv_bubble", 10'b0);
    issue(BAD_OP, 32'h120);
    tick();
    ctrl("badop_ctrl", 10'b0);
    issue(BEQ, 32'h124);
    tick();
    ctrl("beq_ctrl", 10'b01_0010_0001);
    chk("beq_off", d.extended_branch_offset_id_ex, 32'hFFFFFFFF);
    issue(LW_8, 32'h128);
    tick();
    issue(ADD_3_8_2, 32'h12C);
    #1;
    chk("rst_pre_stall", {31'd0, d.stall}, {31'd0, HZ});
    reset = 1'b0;
    #1;
    ctrl("rst_mid_ctrl", 10'b0);
    chk("rst_mid_stall", {31'd0, d.stall}, 0);
    chk("rst_mid_rt", {27'd0, d.next_instruction_20_16_id_ex}, 0);
    @(negedge clk);
    reset = 1'b1;
    issue(ADD_8_9_10, 32'h200);
    tick();
    ctrl("rst_rel_add", 10'b10_0100_0101);
    chk("rst_rel_rd1", d.read_data_1_id_ex, 0);
    chk("rst_rel_rd2", d.read_data_2_id_ex, 0);
    chk("rst_rel_nxt", d.supposed_next_address_id_ex, 32'h200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL use clock clk and reset reset, asynchronous, active-low.
REQ-002 Ports SHALL be: clk in 1 clock; reset in 1 async active-low reset; instr_if_id in 32 IF/ID instruction; pc_plus4_if_id in 32 IF/ID PC+4; valid_if_id in 1 IF/ID slot holds a real instruction; flush in 1 branch-taken squash.
REQ-003 Write-back ports SHALL be: wb_we in 1 write enable; wb_addr in 5 destination register; wb_data in 32 write data.
REQ-004 ID/EX data outputs SHALL be: read_data_1_id_ex out 32; read_data_2_id_ex out 32; extended_branch_offset_id_ex out 32; supposed_next_address_id_ex out 32; next_instruction_20_16_id_ex out 5; next_instruction_15_11_id_ex out 5.
REQ-005 ID/EX control outputs SHALL be: ctrl_aluOp_id_ex out 2; ctrl_aluSrc_id_ex, ctrl_regDest_id_ex, ctrl_branch_id_ex, ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_regWrite_id_ex, ctrl_memToReg_id_ex out 1 each; valid_id_ex out 1.
REQ-006 Hazard output SHALL be: stall out 1, combinational; when 1, fetch holds PC and IF/ID.

Function
REQ-007 All ID/EX outputs SHALL be registered and update only on the rising edge of clk, giving 1-cycle latency from IF/ID to ID/EX.
REQ-008 Decode SHALL use opcode instr[31:26] as follows.
- 000000 R-type: regDest=1, aluOp=10, regWrite=1.
- 100011 lw: aluSrc=1, aluOp=00, memRead=1, memToReg=1, regWrite=1.
- 101011 sw: aluSrc=1, aluOp=00, memWrite=1.
- 000100 beq: aluOp=01, branch=1.
- 001000 addi: aluSrc=1, aluOp=00, regWrite=1.
- Any other opcode: all controls 0, valid_id_ex=0.
- Every control not listed for an opcode SHALL be 0.
REQ-009 extended_branch_offset_id_ex SHALL be the sign extension of instr[15:0] to 32 bits.
REQ-010 next_instruction_20_16_id_ex SHALL capture instr[20:16]; next_instruction_15_11_id_ex SHALL capture instr[15:11]; supposed_next_address_id_ex SHALL capture pc_plus4_if_id.
REQ-011 The internal register file SHALL be 32x32 with two read ports, rs=instr[25:21] and rt=instr[20:16]. Register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-012 Write-back SHALL occur on the clk rising edge when wb_we=1. A read of a register being written in the same cycle (wb_addr nonzero) SHALL return wb_data (internal bypass).
REQ-013 The load-use hazard is defined as: ctrl_memRead_id_ex=1, valid_id_ex=1, next_instruction_20_16_id_ex nonzero, and the result register equal to rs, or equal to rt for R-type, sw or beq in IF/ID with valid_if_id=1. On a load-use hazard, stall SHALL be 1.
REQ-014 While stall=1, the ID/EX register SHALL load a bubble: all ctrl_* 0, valid_id_ex 0, data fields don't-care. The IF/ID instruction is re-decoded the next cycle.
REQ-015 flush=1 SHALL load a bubble into ID/EX regardless of stall. stall SHALL be forced to 0 while flush=1.
REQ-016 valid_if_id=0 SHALL load a bubble and SHALL force stall to 0.
REQ-017 Priority SHALL be flush > invalid IF/ID > stall > normal decode.
REQ-018 Write-back SHALL proceed normally during stall, flush and bubbles.

Reset
REQ-019 While reset=0, all ID/EX outputs, including valid_id_ex, SHALL be 0 and all 32 registers SHALL be 0.
REQ-020 stall SHALL be 0 during reset.
REQ-021 Reset asserted mid-stall SHALL discard the pending instruction's ID/EX state. The first edge after release SHALL decode normally.

Configuration
REQ-022 With macro DECODE_HAZARD_DETECT_EN defined, REQ-013/REQ-014 stall logic SHALL be present.
REQ-023 Without DECODE_HAZARD_DETECT_EN, stall SHALL be tied 0 and every valid instruction SHALL decode in order. Software or the compiler then inserts NOPs.

Verification
REQ-024 Scenario: reset low, then instr=0x012A4020 (add $8,$9,$10) with $9=5, $10=7 preloaded via write-back. Required: next edge gives aluOp=10, regDest=1, regWrite=1, read_data_1=5, read_data_2=7, 15_11=8.
REQ-025 Scenario: lw instr=0x8C28FFFC, pc_plus4=0x100. Required: extended_branch_offset=0xFFFFFFFC, aluSrc=1, memRead=1, memToReg=1, supposed_next_address=0x100.
REQ-026 Scenario: lw $8 in ID/EX, then add $3,$8,$2 in IF/ID. Required: stall=1 for exactly one cycle, ID/EX is a bubble, add decodes on the following edge. With the macro undefined, stall stays 0.
REQ-027 Scenario: wb_we=1, wb_addr=9, wb_data=0xDEADBEEF in the same cycle as decoding rs=9. Required: read_data_1_id_ex=0xDEADBEEF.
REQ-028 Scenario: write 0x1234 to register 0, then read $0. Required: 0. Scenario: flush=1 together with a hazard. Required: bubble, stall=0.
REQ-029 Scenario: opcode 0x3F. Required: all controls 0, valid_id_ex=0. Scenario: beq instr=0x1109FFFF. Required: branch=1, aluOp=01, offset=0xFFFFFFFF.
